// File: rtl/npu_pkg.sv
// Shared types and constants for the NPU sequencing blocks.
package npu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_STREAM    = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_DONE      = 3'd4
  } fc_sched_state_e;

  localparam int FC1_WORDS = 330;
  localparam int LOGIT_W   = 24;

endpackage

// File: rtl/npu_fc1_sched_if.sv
// Host / FC-engine signal bundle around the FC1 sequencer.
interface npu_fc1_sched_if import npu_pkg::*; #(
  parameter int NUM_PE = 4,
  parameter int CNT_W  = $clog2(FC1_WORDS + 1)
) ();

  logic                      host_w_valid;
  logic [8*NUM_PE-1:0]       host_w_data;
  logic                      host_w_ready;
  logic                      host_start;
  logic                      host_abort;
  logic                      fcn_start;
  logic [8*NUM_PE-1:0]       fcn_w_data;
  logic                      fcn_w_valid;
  logic                      fcn_w_ready;
  logic                      fcn_done;
  logic signed [LOGIT_W-1:0] fcn_logit;
  logic                      busy;
  logic                      done;
  logic                      err_early;
  logic signed [LOGIT_W-1:0] result;
  logic [CNT_W-1:0]          word_cnt;

  // Sequencer side
  modport slave (
    input  host_w_valid, host_w_data, host_start, host_abort,
    input  fcn_w_ready, fcn_done, fcn_logit,
    output host_w_ready, fcn_start, fcn_w_data, fcn_w_valid,
    output busy, done, err_early, result, word_cnt
  );

  // Host and engine side
  modport master (
    output host_w_valid, host_w_data, host_start, host_abort,
    output fcn_w_ready, fcn_done, fcn_logit,
    input  host_w_ready, fcn_start, fcn_w_data, fcn_w_valid,
    input  busy, done, err_early, result, word_cnt
  );

endinterface

// File: rtl/npu_sync_fifo.sv
// Single-clock FIFO with registered storage, flush and occupancy count.
module npu_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      level;
  logic             do_push;
  logic             do_pop;

  // Full blocks a push even when a pop frees a slot in the same cycle
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign full  = (level == FULL_LVL);
  assign empty = (level == '0);
  assign count = level;

endmodule

// File: rtl/npu_fc1_sched.sv
// FC1 sequencer: buffers host weight words, starts the FC engine, streams
// one weight group per handshake and captures the resulting logit.
module npu_fc1_sched import npu_pkg::*; #(
  parameter int NUM_PE     = 4,
  parameter int IN1_N      = 132,
  parameter int OUT1_M     = 10,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  npu_fc1_sched_if.slave   bus
);

  localparam int RUN_WORDS = IN1_N * OUT1_M / NUM_PE;
  localparam int CNT_W     = $clog2(RUN_WORDS + 1);
  localparam int WORD_W    = 8 * NUM_PE;
  localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1;

  fc_sched_state_e           state, state_nxt;
  logic [CNT_W-1:0]          word_cnt_q;
  logic                      done_q;
  logic                      err_q;
  logic signed [LOGIT_W-1:0] result_q;

  logic                      fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [WORD_W-1:0]         fifo_head;
  logic [LVL_W-1:0]          fifo_level;
  logic                      host_ready;
  logic                      run_clr, cnt_inc, capture, set_err;

  // Ready stays low while in reset so nothing is offered before the FIFO is clean
  assign host_ready = ~fifo_full & ~rst;
  assign fifo_push  = bus.host_w_valid & host_ready & ~bus.host_abort;

  npu_sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (bus.host_w_data),
    .pop       (fifo_pop),
    .flush     (bus.host_abort),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    run_clr   = 1'b0;
    cnt_inc   = 1'b0;
    capture   = 1'b0;
    set_err   = 1'b0;
    fifo_pop  = 1'b0;
    if (bus.host_abort) begin
      state_nxt = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: if (bus.host_start) begin
          state_nxt = ST_START;
          run_clr   = 1'b1;
        end
        ST_START: state_nxt = ST_STREAM;
        // An early completion wins over a coincident transfer: the FIFO is left as is
        ST_STREAM: if (bus.fcn_done) begin
          capture   = 1'b1;
          set_err   = 1'b1;
          state_nxt = ST_DONE;
        end else if (!fifo_empty && bus.fcn_w_ready) begin
          fifo_pop = 1'b1;
          cnt_inc  = 1'b1;
          if (word_cnt_q == CNT_W'(RUN_WORDS - 1)) state_nxt = ST_WAIT_DONE;
        end
        ST_WAIT_DONE: if (bus.fcn_done) begin
          capture   = 1'b1;
          state_nxt = ST_DONE;
        end
        ST_DONE: state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.host_abort) begin
      word_cnt_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (run_clr) begin
        word_cnt_q <= '0;
        done_q     <= 1'b0;
        err_q      <= 1'b0;
      end
      if (cnt_inc) word_cnt_q <= word_cnt_q + 1'b1;
      if (capture) done_q     <= 1'b1;
      if (set_err) err_q      <= 1'b1;
    end
  end

  // The logit survives an abort; only reset or the next capture replaces it
  always_ff @(posedge clk) begin
    if (rst)          result_q <= '0;
    else if (capture) result_q <= bus.fcn_logit;
  end

  assign bus.host_w_ready = host_ready;
  assign bus.fcn_start    = (state == ST_START);
  assign bus.fcn_w_valid  = (state == ST_STREAM) & ~fifo_empty;
  assign bus.fcn_w_data   = fifo_empty ? '0 : fifo_head;
  assign bus.busy         = (state != ST_IDLE);
  assign bus.done         = done_q;
  assign bus.err_early    = err_q;
  assign bus.result       = result_q;
  assign bus.word_cnt     = word_cnt_q;

  a_fifo_level : assert property (@(posedge clk) disable iff (rst)
    fifo_full == (fifo_level == LVL_W'(FIFO_DEPTH)));

endmodule

// File: tb/tb_npu_fc1_sched.sv
// Directed bench for npu_fc1_sched with a weight-order scoreboard.
module tb_npu_fc1_sched;

  logic clk;
  logic rst;

  npu_fc1_sched_if #(.NUM_PE(4), .CNT_W(9)) bus ();

  npu_fc1_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_err;
  int          n_checks;
  int          xfer_cnt;
  int          start_pulses;
  int          next_word;
  int          host_limit;
  bit          host_en;
  bit          host_burst;
  bit          rdy_rand;
  bit          rdy_level;
  logic [31:0] q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pat(input int n);
    logic [31:0] v;
    v = n;
    return (v * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic start_run();
    cyc();
    bus.host_start = 1'b1;
    cyc();
    bus.host_start = 1'b0;
  endtask

  task automatic finish_done(input logic signed [23:0] logit);
    bus.fcn_logit = logit;
    bus.fcn_done  = 1'b1;
    cyc();
    bus.fcn_done  = 1'b0;
  endtask

  task automatic wait_xfer(input int target, input int budget);
    int k = 0;
    while (xfer_cnt < target && k < budget) begin
      cyc();
      k++;
    end
    if (xfer_cnt < target) chk("xfer_timeout", xfer_cnt, target);
  endtask

  // Host and engine-ready drivers act 2 units after the edge, after the main sequence
  initial forever begin
    @(posedge clk);
    #2;
    if (host_en && next_word < host_limit &&
        (!host_burst || $urandom_range(0, 3) != 0)) begin
      bus.host_w_valid = 1'b1;
      bus.host_w_data  = pat(next_word);
    end else begin
      bus.host_w_valid = 1'b0;
    end
    bus.fcn_w_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_level;
  end

  // Scoreboard: inputs are stable from negedge to the next posedge
  always @(negedge clk) begin
    bit m_ready;
    m_ready = !rst && (q.size() < 8);
    chk("w_ready", bus.host_w_ready, m_ready);
    if (bus.fcn_start) start_pulses++;
    if (rst || bus.host_abort) begin
      q.delete();
    end else begin
      if (bus.fcn_w_valid && bus.fcn_w_ready && !bus.fcn_done) begin
        if (q.size() == 0) chk("w_valid_empty", 1, 0);
        else begin
          chk("w_data", bus.fcn_w_data, q[0]);
          void'(q.pop_front());
        end
        xfer_cnt++;
      end
      if (bus.host_w_valid && m_ready) begin
        q.push_back(bus.host_w_data);
        next_word++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    n_err = 0; n_checks = 0; xfer_cnt = 0; start_pulses = 0;
    next_word = 0; host_limit = 0;
    host_en = 0; host_burst = 0; rdy_rand = 0; rdy_level = 1;
    rst = 1'b1;
    bus.host_w_valid = 1'b0; bus.host_w_data = '0;
    bus.host_start = 1'b0; bus.host_abort = 1'b0;
    bus.fcn_w_ready = 1'b0; bus.fcn_done = 1'b0; bus.fcn_logit = '0;

    // Reset state
    repeat (3) cyc();
    sample();
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err_early, 0);
    chk("rst_word_cnt", bus.word_cnt, 0);
    chk("rst_result", $signed(bus.result), 0);
    chk("rst_fcn_start", bus.fcn_start, 0);
    chk("rst_fcn_w_valid", bus.fcn_w_valid, 0);
    cyc();
    rst = 1'b0;

    // Preload 8 words, full run with ready always high
    host_en = 1; host_limit = 8;
    k = 0;
    while (next_word < host_limit && k < 100) begin cyc(); k++; end
    sample();
    chk("preload_ready", bus.host_w_ready, 0);
    chk("preload_idle", bus.busy, 0);
    xfer_cnt = 0; start_pulses = 0;
    host_limit = next_word + 330 - q.size();
    start_run();
    sample();
    chk("t1_fcn_start", bus.fcn_start, 1);
    chk("t1_busy", bus.busy, 1);
    chk("t1_valid_in_start", bus.fcn_w_valid, 0);
    wait_xfer(330, 2000);
    sample();
    chk("t1_word_cnt", bus.word_cnt, 330);
    chk("t1_wait_valid", bus.fcn_w_valid, 0);
    chk("t1_wait_done", bus.done, 0);
    cyc();
    finish_done(-24'sd1234);
    sample();
    chk("t1_result", $signed(bus.result), -1234);
    chk("t1_done", bus.done, 1);
    chk("t1_err", bus.err_early, 0);
    chk("t1_busy_done", bus.busy, 1);
    cyc();
    sample();
    chk("t1_idle", bus.busy, 0);
    chk("t1_word_cnt_hold", bus.word_cnt, 330);
    chk("t1_start_pulses", start_pulses, 1);

    // Random engine ready, bursty host
    cyc();
    rdy_rand = 1; host_burst = 1; xfer_cnt = 0;
    host_limit = next_word + 330 - q.size();
    start_run();
    sample();
    chk("t2_done_cleared", bus.done, 0);
    wait_xfer(330, 5000);
    sample();
    chk("t2_word_cnt", bus.word_cnt, 330);
    cyc();
    finish_done(24'sd777);
    sample();
    chk("t2_result", $signed(bus.result), 777);
    chk("t2_done", bus.done, 1);

    // Early completion after 100 transfers
    cyc();
    rdy_rand = 0; rdy_level = 1; host_burst = 0; xfer_cnt = 0;
    host_limit = next_word + 330 - q.size();
    start_run();
    wait_xfer(100, 1000);
    finish_done(-24'sd8);
    sample();
    chk("t3_err", bus.err_early, 1);
    chk("t3_done", bus.done, 1);
    chk("t3_word_cnt", bus.word_cnt, 100);
    chk("t3_result", $signed(bus.result), -8);
    chk("t3_busy", bus.busy, 1);
    cyc();
    host_limit = next_word;
    sample();
    chk("t3_idle", bus.busy, 0);

    // Abort at word 50 with 5 words buffered; coincident push dropped
    cyc();
    xfer_cnt = 0;
    host_limit = next_word + 55 - q.size();
    start_run();
    sample();
    chk("t4_done_cleared", bus.done, 0);
    chk("t4_err_cleared", bus.err_early, 0);
    wait_xfer(50, 1000);
    rdy_level = 0;
    k = 0;
    while (next_word < host_limit && k < 100) begin cyc(); k++; end
    sample();
    chk("t4_word_cnt", bus.word_cnt, 50);
    chk("t4_valid_held", bus.fcn_w_valid, 1);
    cyc();
    host_limit = next_word + 1;
    bus.host_abort = 1'b1;
    cyc();
    bus.host_abort = 1'b0;
    host_en = 0;
    sample();
    chk("t4_busy", bus.busy, 0);
    chk("t4_done", bus.done, 0);
    chk("t4_err", bus.err_early, 0);
    chk("t4_word_cnt_clr", bus.word_cnt, 0);
    chk("t4_result_kept", $signed(bus.result), -8);
    chk("t4_valid", bus.fcn_w_valid, 0);

    // fcn_done while idle is ignored
    cyc();
    finish_done(24'sd999);
    sample();
    chk("t5_idle_result", $signed(bus.result), -8);
    chk("t5_idle_done", bus.done, 0);
    chk("t5_idle_busy", bus.busy, 0);

    // Clean run after abort, with a stray start mid-stream
    cyc();
    host_en = 1; rdy_level = 1; xfer_cnt = 0; start_pulses = 0;
    host_limit = next_word + 330 - q.size();
    start_run();
    wait_xfer(150, 1000);
    bus.host_start = 1'b1;
    cyc();
    bus.host_start = 1'b0;
    wait_xfer(330, 2000);
    sample();
    chk("t5_word_cnt", bus.word_cnt, 330);
    chk("t5_start_pulses", start_pulses, 1);
    chk("t5_busy", bus.busy, 1);
    cyc();
    finish_done(24'sd4660);
    sample();
    chk("t5_result", $signed(bus.result), 4660);
    chk("t5_done", bus.done, 1);
    chk("t5_err", bus.err_early, 0);

    // Reset in the middle of streaming with a full FIFO
    cyc();
    xfer_cnt = 0;
    host_limit = next_word + 330 - q.size();
    start_run();
    wait_xfer(20, 500);
    rdy_level = 0;
    k = 0;
    while (q.size() < 8 && k < 100) begin cyc(); k++; end
    sample();
    chk("t6_valid_before", bus.fcn_w_valid, 1);
    chk("t6_word_cnt_before", bus.word_cnt, 20);
    cyc();
    rst = 1'b1;
    host_en = 0;
    cyc();
    sample();
    chk("t6_busy", bus.busy, 0);
    chk("t6_done", bus.done, 0);
    chk("t6_err", bus.err_early, 0);
    chk("t6_word_cnt", bus.word_cnt, 0);
    chk("t6_result", $signed(bus.result), 0);
    chk("t6_fcn_start", bus.fcn_start, 0);
    chk("t6_fcn_w_valid", bus.fcn_w_valid, 0);
    chk("t6_fcn_w_data", bus.fcn_w_data, 0);
    chk("t6_ready_in_rst", bus.host_w_ready, 0);
    cyc();
    rst = 1'b0;
    cyc();
    sample();
    chk("t6_ready_after", bus.host_w_ready, 1);
    chk("t6_busy_after", bus.busy, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
